// File: rtl/os_generator.sv
// Transmit-side TS1/TS2 ordered-set generator with valid/ready burst streaming.
// Optional EIEOS insertion after every 32nd TS is enabled by defining OS_GENERATOR_EIEOS_EN.
module os_generator #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       substate,
    input  logic [7:0]       linkNumber,
    input  logic [7:0]       laneNumber,
    input  logic [7:0]       rateid,
    input  logic             upconfigure_capability,
    input  logic             start,
    input  logic [CNT_W-1:0] count,
    input  logic             stop,
    input  logic             ready,
    output logic [127:0]     orderedset,
    output logic             valid,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] sent_count
);

    localparam logic [7:0] COM    = 8'hBC;
    localparam logic [7:0] PAD    = 8'hF7;
    localparam logic [7:0] TS1_ID = 8'h2A;
    localparam logic [7:0] TS2_ID = 8'h25;

    typedef enum logic [1:0] {StIdle, StSend, StEieos} state_e;

    function automatic logic [127:0] build_ts(input logic       ts2,
                                              input logic [7:0] link,
                                              input logic [7:0] lane,
                                              input logic [7:0] rate);
        logic [7:0] id;
        id = ts2 ? TS2_ID : TS1_ID;
        return {{10{id}}, 8'h00, rate, 8'h00, lane, link, COM};
    endfunction

    state_e           state_q, state_d;
    logic [127:0]     os_q, os_d;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [CNT_W-1:0] sent_q, sent_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Decoded view of the live inputs, only consumed when start is accepted.
    logic             os_ok;
    logic             is_ts2;
    logic             eie_cap;
    logic [7:0]       link_sel;
    logic [7:0]       lane_sel;
    logic [7:0]       rate_sel;
    logic [CNT_W-1:0] sent_inc;
    logic             finish;

`ifdef OS_GENERATOR_EIEOS_EN
    localparam logic [127:0] EIEOS_WORD = {8{16'hFF00}};
    logic       ts2_q, ts2_d;
    logic       eie_q, eie_d;
    logic       last_q, last_d;
    logic [7:0] link_q, link_d;
    logic [7:0] lane_q, lane_d;
    logic [7:0] rate_q, rate_d;
`endif

    always_comb begin
        os_ok    = 1'b0;
        is_ts2   = 1'b0;
        eie_cap  = 1'b0;
        link_sel = PAD;
        lane_sel = PAD;
        case (substate)
            4'd2: begin
                os_ok   = 1'b1;
                eie_cap = 1'b1;
            end
            4'd3: begin
                os_ok  = 1'b1;
                is_ts2 = 1'b1;
            end
            4'd4, 4'd5: begin
                os_ok    = 1'b1;
                eie_cap  = 1'b1;
                link_sel = linkNumber;
            end
            4'd6, 4'd7: begin
                os_ok    = 1'b1;
                eie_cap  = 1'b1;
                link_sel = linkNumber;
                lane_sel = laneNumber;
            end
            4'd8: begin
                os_ok    = 1'b1;
                is_ts2   = 1'b1;
                eie_cap  = 1'b1;
                link_sel = linkNumber;
                lane_sel = laneNumber;
            end
            default: os_ok = 1'b0;
        endcase
        rate_sel = rateid;
        if (is_ts2) rate_sel[6] = upconfigure_capability;
    end

    assign sent_inc = (sent_q == {CNT_W{1'b1}}) ? sent_q : sent_q + CNT_W'(1);
    assign finish   = (cnt_q != '0) && (sent_inc == cnt_q);

    always_comb begin
        state_d = state_q;
        os_d    = os_q;
        valid_d = valid_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        sent_d  = sent_q;
        cnt_d   = cnt_q;
`ifdef OS_GENERATOR_EIEOS_EN
        ts2_d  = ts2_q;
        eie_d  = eie_q;
        last_d = last_q;
        link_d = link_q;
        lane_d = lane_q;
        rate_d = rate_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    sent_d = '0;
                    cnt_d  = count;
`ifdef OS_GENERATOR_EIEOS_EN
                    ts2_d  = is_ts2;
                    eie_d  = eie_cap;
                    last_d = 1'b0;
                    link_d = link_sel;
                    lane_d = lane_sel;
                    rate_d = rate_sel;
`endif
                    if (os_ok) begin
                        state_d = StSend;
                        valid_d = 1'b1;
                        busy_d  = 1'b1;
                        os_d    = build_ts(is_ts2, link_sel, lane_sel, rate_sel);
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            StSend: begin
                if (ready) sent_d = sent_inc;
                // A stop coinciding with the final transfer still counts it but suppresses done.
                if (stop) begin
                    state_d = StIdle;
                    valid_d = 1'b0;
                    busy_d  = 1'b0;
                    os_d    = '0;
                end else if (ready) begin
`ifdef OS_GENERATOR_EIEOS_EN
                    if (eie_q && (sent_inc[4:0] == 5'd0)) begin
                        state_d = StEieos;
                        os_d    = EIEOS_WORD;
                        last_d  = finish;
                    end else
`endif
                    if (finish) begin
                        state_d = StIdle;
                        valid_d = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        os_d    = '0;
                    end
                end
            end
            StEieos: begin
`ifdef OS_GENERATOR_EIEOS_EN
                if (stop || (ready && last_q)) begin
                    state_d = StIdle;
                    valid_d = 1'b0;
                    busy_d  = 1'b0;
                    done_d  = !stop;
                    os_d    = '0;
                end else if (ready) begin
                    state_d = StSend;
                    os_d    = build_ts(ts2_q, link_q, lane_q, rate_q);
                end
`else
                state_d = StIdle;
                valid_d = 1'b0;
                busy_d  = 1'b0;
                os_d    = '0;
`endif
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= StIdle;
            os_q    <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sent_q  <= '0;
            cnt_q   <= '0;
`ifdef OS_GENERATOR_EIEOS_EN
            ts2_q   <= 1'b0;
            eie_q   <= 1'b0;
            last_q  <= 1'b0;
            link_q  <= '0;
            lane_q  <= '0;
            rate_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            os_q    <= os_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            sent_q  <= sent_d;
            cnt_q   <= cnt_d;
`ifdef OS_GENERATOR_EIEOS_EN
            ts2_q   <= ts2_d;
            eie_q   <= eie_d;
            last_q  <= last_d;
            link_q  <= link_d;
            lane_q  <= lane_d;
            rate_q  <= rate_d;
`endif
        end
    end

    assign orderedset = os_q;
    assign valid      = valid_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign sent_count = sent_q;

endmodule
